// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter in front of a single-port RAM
module ram_arbiter #(
  parameter int AddressSize = 4,
  parameter int WordSize    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic                   b_valid,
  output logic                   a_ready,
  output logic                   b_ready,
  input  logic                   a_we,
  input  logic                   b_we,
  input  logic [AddressSize-1:0] a_addr,
  input  logic [AddressSize-1:0] b_addr,
  input  logic [WordSize-1:0]    a_wdata,
  input  logic [WordSize-1:0]    b_wdata,
  output logic                   a_resp,
  output logic                   b_resp,
  output logic [WordSize-1:0]    resp_rdata,
  output logic [AddressSize-1:0] ram_address,
  output logic [WordSize-1:0]    ram_data_in,
  output logic                   ram_we,
  output logic                   ram_oe,
  input  logic [WordSize-1:0]    ram_data_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]             state;
  logic                   last_grant;  // 0 = A, 1 = B
  logic                   cur_port;    // port of the request in flight
  logic                   cur_we;      // type of the request in flight
  logic                   grant_a;
  logic                   grant_b;
  logic                   sel_we;
  logic [AddressSize-1:0] sel_addr;
  logic [WordSize-1:0]    sel_wdata;

  // Grant: lone requester wins; on a tie the port that did not win last time wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && state == IDLE) begin
      if (a_valid && (!b_valid || last_grant)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Mux the granted port's request fields for capture on the accept edge.
  always_comb begin
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
  end

  // Request sequencing: accept in IDLE, drive the RAM for one cycle, then pulse the response.
  // The RAM command registers double as the latched address and write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_port    <= 1'b0;
      cur_we      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      a_resp      <= 1'b0;
      b_resp      <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            cur_port    <= grant_b;
            last_grant  <= grant_b;
            cur_we      <= sel_we;
            ram_address <= sel_addr;
            ram_we      <= sel_we;
            ram_oe      <= !sel_we;
            ram_data_in <= sel_we ? sel_wdata : '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we     <= 1'b0;
          ram_oe     <= 1'b0;
          resp_rdata <= cur_we ? '0 : ram_data_out;
          a_resp     <= !cur_port;
          b_resp     <= cur_port;
          state      <= RESP;
        end
        RESP: begin
          a_resp <= 1'b0;
          b_resp <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
